// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, key codes and operator encodings for the calculator sequencer
package calc_pkg;
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    SHOW    = 3'd3,
    ERR     = 3'd4
  } state_t;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/calc_sequencer_key_classifier.sv
// key_classifier: combinational decode of a key code into digit/operator/enter/clear classes
//   key_code : decoded keypad value
//   is_digit : 0-9
//   is_op    : add or subtract
//   is_ent   : enter/equals
//   is_clr   : clear
// Codes D and F fall into no class and are therefore ignored upstream.
module key_classifier
  import calc_pkg::*;
(
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_ent,
  output logic       is_clr
);
  always_comb begin
    is_digit = key_code <= 4'd9;
    is_op = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    is_ent = key_code == KEY_ENT;
    is_clr = key_code == KEY_CLR;
  end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM capturing operand A, operator and operand B, launching the ALU and holding the result
//   clk, reset (async, active-low)
//   key_valid/key_code        : decoded key events
//   operand_in/operand_ovr    : current entry value and its out-of-range flag
//   alu_done/alu_result/alu_ovf : ALU completion
//   entry_clear, op_a, op_b, alu_op, alu_start : datapath control (all registered)
//   result_out, result_valid, error, state_dbg : display/status (all registered)
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [7:0] operand_in,
  input  logic       operand_ovr,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_ovf,
  output logic       entry_clear,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       alu_op,
  output logic       alu_start,
  output logic [7:0] result_out,
  output logic       result_valid,
  output logic       error,
  output logic [2:0] state_dbg
);
  localparam int DC_W = $clog2(DIGITS + 1);
  state_t state, state_n;
  logic [DC_W-1:0] digit_cnt, digit_cnt_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [7:0] shadow, op_a_n, op_b_n, result_n;
  logic shadow_ovr, dig_d;
  logic alu_op_n, entry_clear_n, alu_start_n, result_valid_n;
  logic is_digit, is_op, is_ent, is_clr;
  logic kd, ko, ke, kc, key_op;
  key_classifier u_cls (
    .key_code(key_code),
    .is_digit(is_digit),
    .is_op(is_op),
    .is_ent(is_ent),
    .is_clr(is_clr)
  );
  assign kd = key_valid & is_digit;
  assign ko = key_valid & is_op;
  assign ke = key_valid & is_ent;
  assign kc = key_valid & is_clr;
  assign key_op = key_code == KEY_SUB ? OP_SUB : OP_ADD;
  assign state_dbg = state;
  always_comb begin
    state_n = state;
    digit_cnt_n = digit_cnt;
    to_cnt_n = to_cnt;
    op_a_n = op_a;
    op_b_n = op_b;
    alu_op_n = alu_op;
    result_n = result_out;
    result_valid_n = result_valid;
    entry_clear_n = 1'b0;
    alu_start_n = 1'b0;
    if (kc) begin
      state_n = ENTER_A;
      entry_clear_n = 1'b1;
      digit_cnt_n = '0;
      result_valid_n = 1'b0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (kd) begin
            if (digit_cnt == DC_W'(DIGITS)) state_n = ERR;
            else digit_cnt_n = digit_cnt + 1'b1;
          end else if (ko && state == ENTER_B) begin
            alu_op_n = key_op;
          end else if (ko && digit_cnt != '0) begin
            if (shadow_ovr) state_n = ERR;
            else begin
              op_a_n = shadow;
              alu_op_n = key_op;
              entry_clear_n = 1'b1;
              digit_cnt_n = '0;
              state_n = ENTER_B;
            end
          end else if (ke && state == ENTER_B && digit_cnt != '0) begin
            if (shadow_ovr) state_n = ERR;
            else begin
              op_b_n = shadow;
              entry_clear_n = 1'b1;
              digit_cnt_n = '0;
              alu_start_n = 1'b1;
              to_cnt_n = '0;
              state_n = EXEC;
            end
          end
        end
        EXEC: begin
          if (alu_done) begin
            result_n = alu_result;
            result_valid_n = 1'b1;
            state_n = alu_ovf ? ERR : SHOW;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            state_n = ERR;
          end else begin
            to_cnt_n = to_cnt + 1'b1;
          end
        end
        SHOW: begin
          // The digit already landed in the shift register cleared at the E key, so it counts as the first digit.
          if (kd) begin
            result_valid_n = 1'b0;
            digit_cnt_n = DC_W'(1);
            state_n = ENTER_A;
          end else if (ko) begin
            op_a_n = result_out;
            alu_op_n = key_op;
            entry_clear_n = 1'b1;
            digit_cnt_n = '0;
            state_n = ENTER_B;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ENTER_A;
      digit_cnt <= '0;
      to_cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      alu_op <= OP_ADD;
      result_out <= '0;
      result_valid <= 1'b0;
      entry_clear <= 1'b0;
      alu_start <= 1'b0;
      error <= 1'b0;
      shadow <= '0;
      shadow_ovr <= 1'b0;
      dig_d <= 1'b0;
    end else begin
      state <= state_n;
      digit_cnt <= digit_cnt_n;
      to_cnt <= to_cnt_n;
      op_a <= op_a_n;
      op_b <= op_b_n;
      alu_op <= alu_op_n;
      result_out <= result_n;
      result_valid <= result_valid_n;
      entry_clear <= entry_clear_n;
      alu_start <= alu_start_n;
      error <= state_n == ERR;
      // The entry path updates operand_in one cycle after a digit key, so capture it then.
      dig_d <= kd;
      if (dig_d) begin
        shadow <= operand_in;
        shadow_ovr <= operand_ovr;
      end
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard-driven self-checking bench for calc_sequencer
module tb_calc_sequencer;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] operand_in = 8'h0;
  logic operand_ovr = 1'b0;
  logic alu_done = 1'b0;
  logic [7:0] alu_result = 8'h0;
  logic alu_ovf = 1'b0;
  logic entry_clear, alu_op, alu_start, result_valid, error;
  logic [7:0] op_a, op_b, result_out;
  logic [2:0] state_dbg;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic op;
    logic [7:0] r;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int acc = 0;
  logic [7:0] last_res = 8'h0;
  calc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .operand_in(operand_in),
    .operand_ovr(operand_ovr),
    .alu_done(alu_done),
    .alu_result(alu_result),
    .alu_ovf(alu_ovf),
    .entry_clear(entry_clear),
    .op_a(op_a),
    .op_b(op_b),
    .alu_op(alu_op),
    .alu_start(alu_start),
    .result_out(result_out),
    .result_valid(result_valid),
    .error(error),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  // Keypad entry path model: operand_in follows the digits typed since the last clearing key.
  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code = k;
    if (k <= 4'd9) begin
      acc = acc * 10 + int'(k);
      operand_in = acc[7:0];
    end else begin
      acc = 0;
      operand_in = 8'hEE;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask
  task automatic run_alu(input int lat, input logic ovf);
    exp_t e;
    int n = 0;
    while (!alu_start && n < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (alu_start !== 1'b1) begin
      errors++;
      $display("FAIL alu_start_seen: alu_start=%b required 1 within 5 cycles", alu_start);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty, required an entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (op_a !== e.a) begin
      errors++;
      $display("FAIL op_a: got %h required %h", op_a, e.a);
    end
    checks++;
    if (op_b !== e.b) begin
      errors++;
      $display("FAIL op_b: got %h required %h", op_b, e.b);
    end
    checks++;
    if (alu_op !== e.op) begin
      errors++;
      $display("FAIL alu_op: got %b required %b", alu_op, e.op);
    end
    @(posedge clk);
    #1;
    checks++;
    if (alu_start !== 1'b0) begin
      errors++;
      $display("FAIL alu_start_pulse: got %b required 0 on second EXEC cycle", alu_start);
    end
    repeat (lat - 1) begin
      @(posedge clk);
      #1;
    end
    alu_done = 1'b1;
    alu_result = e.r;
    alu_ovf = ovf;
    @(posedge clk);
    #1;
    alu_done = 1'b0;
    alu_ovf = 1'b0;
    checks++;
    if ({result_valid, result_out} !== {1'b1, e.r}) begin
      errors++;
      $display("FAIL result: valid=%b out=%h required valid=1 out=%h", result_valid, result_out, e.r);
    end
    checks++;
    if (state_dbg !== (ovf ? ERR : SHOW)) begin
      errors++;
      $display("FAIL result_state: got %0d required %0d", state_dbg, ovf ? ERR : SHOW);
    end
    last_res = e.r;
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({entry_clear, op_a, op_b, alu_op, alu_start, result_out, result_valid, error, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required all zero",
               {entry_clear, op_a, op_b, alu_op, alu_start, result_out, result_valid, error, state_dbg});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_add();
    press(4'd1);
    press(4'd2);
    press(KEY_ADD);
    checks++;
    if ({state_dbg, entry_clear, op_a} !== {ENTER_B, 1'b1, 8'd12}) begin
      errors++;
      $display("FAIL add_op_key: state=%0d clr=%b op_a=%0d required 1,1,12", state_dbg, entry_clear, op_a);
    end
    press(4'd3);
    sb.push_back(exp_t'{8'd12, 8'd3, OP_ADD, 8'd15});
    press(KEY_ENT);
    run_alu(3, 1'b0);
    press(4'd9);
    checks++;
    if ({state_dbg, result_valid, result_out} !== {ENTER_A, 1'b0, 8'd15}) begin
      errors++;
      $display("FAIL show_digit: state=%0d valid=%b out=%0d required 0,0,15", state_dbg, result_valid, result_out);
    end
    press(KEY_SUB);
    press(4'd2);
    sb.push_back(exp_t'{8'd9, 8'd2, OP_SUB, 8'd7});
    press(KEY_ENT);
    run_alu(2, 1'b0);
  endtask
  task automatic test_sub_chain();
    press(4'd5);
    press(KEY_SUB);
    press(4'd7);
    sb.push_back(exp_t'{8'd5, 8'd7, OP_SUB, 8'h82});
    press(KEY_ENT);
    run_alu(2, 1'b0);
    press(KEY_ADD);
    checks++;
    if ({state_dbg, op_a, entry_clear} !== {ENTER_B, 8'h82, 1'b1}) begin
      errors++;
      $display("FAIL chain: state=%0d op_a=%h clr=%b required 1,82,1", state_dbg, op_a, entry_clear);
    end
    press(4'd1);
    sb.push_back(exp_t'{8'h82, 8'd1, OP_ADD, 8'h83});
    press(KEY_ENT);
    run_alu(1, 1'b0);
    press(KEY_CLR);
    press(4'd1);
    press(KEY_ADD);
    press(4'd1);
    sb.push_back(exp_t'{8'd1, 8'd1, OP_ADD, 8'h7F});
    press(KEY_ENT);
    run_alu(1, 1'b1);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL ovf_error: error=%b required 1", error);
    end
    press(KEY_CLR);
  endtask
  task automatic test_ovr_err();
    operand_ovr = 1'b1;
    press(4'd3);
    press(KEY_ADD);
    checks++;
    if ({state_dbg, error} !== {ERR, 1'b1}) begin
      errors++;
      $display("FAIL ovr_err: state=%0d error=%b required 4,1", state_dbg, error);
    end
    operand_ovr = 1'b0;
    press(4'd5);
    press(KEY_ENT);
    checks++;
    if ({state_dbg, error, alu_start} !== {ERR, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL err_sticky: state=%0d error=%b start=%b required 4,1,0", state_dbg, error, alu_start);
    end
    press(KEY_CLR);
    checks++;
    if ({state_dbg, error, entry_clear} !== {ENTER_A, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL err_clear: state=%0d error=%b clr=%b required 0,0,1", state_dbg, error, entry_clear);
    end
  endtask
  task automatic test_digit_limit();
    for (int i = 1; i <= 4; i++) press(4'(i));
    checks++;
    if ({state_dbg, error} !== {ENTER_A, 1'b0}) begin
      errors++;
      $display("FAIL four_digits: state=%0d error=%b required 0,0", state_dbg, error);
    end
    press(4'd5);
    checks++;
    if ({state_dbg, error} !== {ERR, 1'b1}) begin
      errors++;
      $display("FAIL fifth_digit: state=%0d error=%b required 4,1", state_dbg, error);
    end
    press(KEY_CLR);
  endtask
  task automatic test_timeout();
    int n = 0;
    press(4'd1);
    press(KEY_ADD);
    press(4'd2);
    press(KEY_ENT);
    checks++;
    if (alu_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start: alu_start=%b required 1", alu_start);
    end
    while (!error && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 16 || state_dbg !== ERR) begin
      errors++;
      $display("FAIL timeout: error after %0d cycles state=%0d required 16 cycles state 4", n, state_dbg);
    end
    press(KEY_CLR);
  endtask
  task automatic test_clr_vs_done();
    press(4'd1);
    press(KEY_ADD);
    press(4'd1);
    press(KEY_ENT);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code = KEY_CLR;
    alu_done = 1'b1;
    alu_result = 8'h55;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    alu_done = 1'b0;
    checks++;
    if ({state_dbg, result_valid, entry_clear, result_out} !== {ENTER_A, 1'b0, 1'b1, last_res}) begin
      errors++;
      $display("FAIL clr_vs_done: state=%0d valid=%b clr=%b out=%h required 0,0,1,%h",
               state_dbg, result_valid, entry_clear, result_out, last_res);
    end
  endtask
  task automatic test_async_reset();
    logic bad = 1'b0;
    press(4'd2);
    press(KEY_SUB);
    press(4'd2);
    press(KEY_ENT);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({entry_clear, op_a, op_b, alu_op, alu_start, result_out, result_valid, error, state_dbg} !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h required all zero",
               {entry_clear, op_a, op_b, alu_op, alu_start, result_out, result_valid, error, state_dbg});
    end
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (alu_start !== 1'b0 || state_dbg !== ENTER_A) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_reset: spurious alu_start or state leave, start=%b state=%0d required 0,0", alu_start, state_dbg);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub_chain();
    test_ovr_err();
    test_digit_limit();
    test_timeout();
    test_clr_vs_done();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
